// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the safe-lock seven-segment display path:
// glyph patterns, the glyph mask and default output polarities.
package seg_scan_driver_pkg;

    typedef logic [3:0] code_t;
    typedef logic [6:0] glyph_t;

    localparam glyph_t GLYPH_MASK  = 7'b1000000;
    localparam glyph_t GLYPH_BLANK = 7'b0000000;
    localparam glyph_t GLYPH_FOUR  = 7'b0110011;
    localparam glyph_t GLYPH_E     = 7'b1001111;
    localparam glyph_t GLYPH_R     = 7'b0000101;

    localparam code_t CODE_E     = 4'hC;
    localparam code_t CODE_R     = 4'hD;
    localparam code_t CODE_BLANK = 4'hF;

    localparam bit DEF_SEG_ACTIVE_LOW = 1'b1;
    localparam bit DEF_AN_ACTIVE_LOW  = 1'b1;

endpackage

// File: rtl/seg_scan_driver_glyph_decode.sv
// Code to raw active-high segment pattern {a,b,c,d,e,f,g}.
// Polarity is applied by the caller.
module seg_glyph_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_raw
);

    glyph_t pat;

    always_comb begin
        pat = GLYPH_BLANK;
        case (code)
            4'h0:    pat = 7'b1111110;
            4'h1:    pat = 7'b0110000;
            4'h2:    pat = 7'b1101101;
            4'h3:    pat = 7'b1111001;
            4'h4:    pat = GLYPH_FOUR;
            4'h5:    pat = 7'b1011011;
            4'h6:    pat = 7'b1011111;
            4'h7:    pat = 7'b1110000;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1111011;
            CODE_E:  pat = GLYPH_E;
            CODE_R:  pat = GLYPH_R;
            default: pat = GLYPH_BLANK;
        endcase
        seg_raw = (pat == GLYPH_FOUR) ? (pat ^ GLYPH_MASK) : pat;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver with double-buffered
// loading, per-digit blink and inter-digit anti-ghost blanking.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = DEF_SEG_ACTIVE_LOW,
    parameter bit AN_ACTIVE_LOW  = DEF_AN_ACTIVE_LOW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] codes_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic                    load_ack,
    output logic                    pending,
    output logic                    frame_tick,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int CW = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [CW-1:0] CODES_RST = {NUM_DIGITS{CODE_BLANK}};

    logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]         dig_idx_q, dig_idx_d;
    logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [CW-1:0]         shadow_codes_q, shadow_codes_d;
    logic [NUM_DIGITS-1:0] shadow_blink_q, shadow_blink_d;
    logic [CW-1:0]         disp_codes_q, disp_codes_d;
    logic [NUM_DIGITS-1:0] disp_blink_q, disp_blink_d;
    logic                  pending_q, pending_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  slot_end;
    logic                  last_dig;
    logic                  bnd;
    logic [3:0]            cur_code;
    logic [6:0]            cur_glyph;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    assign cur_code = disp_codes_q[{dig_idx_q, 2'b00} +: 4];

    seg_glyph_decode u_glyph (
        .code    (cur_code),
        .seg_raw (cur_glyph)
    );

    always_comb begin
        slot_end = (slot_cnt_q == SW'(SCAN_DIV - 1));
        last_dig = (dig_idx_q == DW'(NUM_DIGITS - 1));
        bnd      = slot_end & last_dig;

        slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
        dig_idx_d  = dig_idx_q;
        if (slot_end) begin
            dig_idx_d = last_dig ? '0 : dig_idx_q + 1'b1;
        end

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (bnd) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        shadow_codes_d = load ? codes_in : shadow_codes_q;
        shadow_blink_d = load ? blink_in : shadow_blink_q;
        pending_d      = load | (pending_q & ~bnd);

        // Commit takes the shadow as it was before any same-edge load.
        disp_codes_d = disp_codes_q;
        disp_blink_d = disp_blink_q;
        if (bnd && pending_q) begin
            disp_codes_d = shadow_codes_q;
            disp_blink_d = shadow_blink_q;
        end
        load_ack_d   = bnd & pending_q;
        frame_tick_d = bnd;

        an_raw  = '0;
        seg_raw = GLYPH_BLANK;
        if (slot_cnt_q >= SW'(BLANK_CYCLES)) begin
            an_raw[dig_idx_q] = 1'b1;
            if (!(disp_blink_q[dig_idx_q] && blink_phase_q)) begin
                seg_raw = cur_glyph;
            end
        end
        seg_d = seg_raw ^ SEG_OFF;
        an_d  = an_raw ^ AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q     <= '0;
            dig_idx_q      <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            shadow_codes_q <= CODES_RST;
            shadow_blink_q <= '0;
            disp_codes_q   <= CODES_RST;
            disp_blink_q   <= '0;
            pending_q      <= 1'b0;
            load_ack_q     <= 1'b0;
            frame_tick_q   <= 1'b0;
            seg_q          <= SEG_OFF;
            an_q           <= AN_OFF;
        end else begin
            slot_cnt_q     <= slot_cnt_d;
            dig_idx_q      <= dig_idx_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
            shadow_codes_q <= shadow_codes_d;
            shadow_blink_q <= shadow_blink_d;
            disp_codes_q   <= disp_codes_d;
            disp_blink_q   <= disp_blink_d;
            pending_q      <= pending_d;
            load_ack_q     <= load_ack_d;
            frame_tick_q   <= frame_tick_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with a 4-digit,
// 4-cycle-slot configuration (16-cycle frame).
module tb_seg_scan_driver;
    import seg_scan_driver_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] codes_in;
    logic [3:0]  blink_in;
    logic        load_ack;
    logic        pending;
    logic        frame_tick;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BLANK_CYCLES   (1),
        .BLINK_FRAMES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .codes_in   (codes_in),
        .blink_in   (blink_in),
        .load_ack   (load_ack),
        .pending    (pending),
        .frame_tick (frame_tick),
        .seg        (seg),
        .an         (an)
    );

    // cyc = edges since the reset edge; outputs seen at cyc reflect
    // the scan position (cyc-1) mod 16.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int t);
        do tick(); while (cyc % 16 != t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b0;
        codes_in = '0;
        blink_in = '0;
        @(posedge clk);
        #1;
        cyc = 0;
        n_checks += 5;
        if (an !== 4'hF) begin
            n_fail++; $display("FAIL reset_an: got %h want f", an);
        end
        if (seg !== 7'h7F) begin
            n_fail++; $display("FAIL reset_seg: got %h want 7f", seg);
        end
        if (load_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_ack: got %b want 0", load_ack);
        end
        if (frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_ftick: got %b want 0", frame_tick);
        end
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending: got %b want 0", pending);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int pos;
        logic [3:0] e_an;
        logic e_ft;
        for (int i = 0; i < 40; i++) begin
            tick();
            pos = (cyc - 1) % 16;
            e_an = 4'hF;
            if (pos % 4 != 0) e_an[pos/4] = 1'b0;
            e_ft = (cyc % 16 == 0);
            n_checks += 4;
            if (an !== e_an) begin
                n_fail++; $display("FAIL idle_an cyc=%0d: got %b want %b", cyc, an, e_an);
            end
            if (seg !== 7'h7F) begin
                n_fail++; $display("FAIL idle_seg cyc=%0d: got %h want 7f", cyc, seg);
            end
            if (frame_tick !== e_ft) begin
                n_fail++; $display("FAIL idle_ftick cyc=%0d: got %b want %b", cyc, frame_tick, e_ft);
            end
            if (load_ack !== 1'b0) begin
                n_fail++; $display("FAIL idle_ack cyc=%0d: got %b want 0", cyc, load_ack);
            end
        end
    endtask

    task automatic test_load();
        tick_to(5);
        codes_in = 16'h3210;
        blink_in = 4'b0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++; $display("FAIL load_pending: got %b want 1", pending);
        end
        do begin
            tick();
            if (cyc % 16 != 0) begin
                n_checks += 2;
                if (load_ack !== 1'b0) begin
                    n_fail++; $display("FAIL load_early_ack cyc=%0d: got %b want 0", cyc, load_ack);
                end
                if (seg !== 7'h7F) begin
                    n_fail++; $display("FAIL load_early_seg cyc=%0d: got %h want 7f", cyc, seg);
                end
            end
        end while (cyc % 16 != 0);
        n_checks += 2;
        if (load_ack !== 1'b1) begin
            n_fail++; $display("FAIL load_ack: got %b want 1", load_ack);
        end
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL load_pend_clr: got %b want 0", pending);
        end
        tick_to(2);
        n_checks += 3;
        if (an !== 4'b1110) begin
            n_fail++; $display("FAIL load_d0_an: got %b want 1110", an);
        end
        if (seg !== 7'b0000001) begin
            n_fail++; $display("FAIL load_d0_seg: got %b want 0000001", seg);
        end
        if (load_ack !== 1'b0) begin
            n_fail++; $display("FAIL load_ack_len: got %b want 0", load_ack);
        end
        tick_to(14);
        n_checks += 2;
        if (an !== 4'b0111) begin
            n_fail++; $display("FAIL load_d3_an: got %b want 0111", an);
        end
        if (seg !== 7'b0000110) begin
            n_fail++; $display("FAIL load_d3_seg: got %b want 0000110", seg);
        end
    endtask

    task automatic test_glyphs();
        logic [6:0] e_four;
        e_four = ~(7'b0110011 ^ GLYPH_MASK);
        codes_in = 16'hDC4B;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick_to(0);
        n_checks++;
        if (load_ack !== 1'b1) begin
            n_fail++; $display("FAIL glyph_ack: got %b want 1", load_ack);
        end
        tick_to(2);
        n_checks++;
        if (seg !== 7'h7F) begin
            n_fail++; $display("FAIL glyph_B: got %b want 1111111", seg);
        end
        tick_to(6);
        n_checks += 2;
        if (seg !== e_four) begin
            n_fail++; $display("FAIL glyph_4: got %b want %b", seg, e_four);
        end
        if (an !== 4'b1101) begin
            n_fail++; $display("FAIL glyph_4_an: got %b want 1101", an);
        end
        tick_to(10);
        n_checks++;
        if (seg !== 7'b0110000) begin
            n_fail++; $display("FAIL glyph_E: got %b want 0110000", seg);
        end
        tick_to(14);
        n_checks++;
        if (seg !== 7'b1111010) begin
            n_fail++; $display("FAIL glyph_r: got %b want 1111010", seg);
        end
    endtask

    task automatic test_back_to_back();
        tick_to(2);
        codes_in = 16'h1111;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        codes_in = 16'h2222;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick_to(0);
        n_checks++;
        if (load_ack !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ack: got %b want 1", load_ack);
        end
        tick();
        n_checks++;
        if (load_ack !== 1'b0) begin
            n_fail++; $display("FAIL b2b_single_ack: got %b want 0", load_ack);
        end
        for (int d = 0; d < 4; d++) begin
            tick_to(4 * d + 2);
            n_checks++;
            if (seg !== 7'b0010010) begin
                n_fail++; $display("FAIL b2b_d%0d_seg: got %b want 0010010", d, seg);
            end
        end
        codes_in = 16'h7777;
        load = 1'b1;
        tick();
        codes_in = 16'h5555;
        tick();
        load = 1'b0;
        n_checks += 2;
        if (load_ack !== 1'b1) begin
            n_fail++; $display("FAIL bnd_load_ack: got %b want 1", load_ack);
        end
        if (pending !== 1'b1) begin
            n_fail++; $display("FAIL bnd_load_pending: got %b want 1", pending);
        end
        tick_to(2);
        n_checks++;
        if (seg !== 7'b0001111) begin
            n_fail++; $display("FAIL bnd_old_seg: got %b want 0001111", seg);
        end
        tick_to(0);
        n_checks += 2;
        if (load_ack !== 1'b1) begin
            n_fail++; $display("FAIL bnd_second_ack: got %b want 1", load_ack);
        end
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL bnd_pend_clr: got %b want 0", pending);
        end
        tick_to(2);
        n_checks++;
        if (seg !== 7'b0100100) begin
            n_fail++; $display("FAIL bnd_new_seg: got %b want 0100100", seg);
        end
    endtask

    task automatic test_blink();
        int n;
        logic [6:0] e_seg;
        codes_in = 16'h8888;
        blink_in = 4'b0001;
        load = 1'b1;
        tick();
        load = 1'b0;
        blink_in = 4'b0000;
        tick_to(0);
        for (int f = 0; f < 4; f++) begin
            tick_to(2);
            n = cyc / 16;
            e_seg = (((n / 2) % 2) == 1) ? 7'h7F : 7'h00;
            n_checks += 2;
            if (seg !== e_seg) begin
                n_fail++; $display("FAIL blink_d0 frame=%0d: got %h want %h", n, seg, e_seg);
            end
            if (an !== 4'b1110) begin
                n_fail++; $display("FAIL blink_d0_an frame=%0d: got %b want 1110", n, an);
            end
            tick_to(6);
            n_checks += 2;
            if (seg !== 7'h00) begin
                n_fail++; $display("FAIL blink_d1 frame=%0d: got %h want 00", n, seg);
            end
            if (an !== 4'b1101) begin
                n_fail++; $display("FAIL blink_d1_an frame=%0d: got %b want 1101", n, an);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick_to(8);
        codes_in = 16'h0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pending_pre: got %b want 1", pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        n_checks += 5;
        if (an !== 4'hF) begin
            n_fail++; $display("FAIL rmid_an: got %b want 1111", an);
        end
        if (seg !== 7'h7F) begin
            n_fail++; $display("FAIL rmid_seg: got %h want 7f", seg);
        end
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL rmid_pending: got %b want 0", pending);
        end
        if (load_ack !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ack: got %b want 0", load_ack);
        end
        if (frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ftick: got %b want 0", frame_tick);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (load_ack !== 1'b0) begin
                n_fail++; $display("FAIL rmid_late_ack cyc=%0d: got %b want 0", cyc, load_ack);
            end
            if (cyc == 2) begin
                n_checks += 2;
                if (an !== 4'b1110) begin
                    n_fail++; $display("FAIL rmid_restart_an: got %b want 1110", an);
                end
                if (seg !== 7'h7F) begin
                    n_fail++; $display("FAIL rmid_restart_seg: got %h want 7f", seg);
                end
            end
            if (cyc == 16) begin
                n_checks++;
                if (frame_tick !== 1'b1) begin
                    n_fail++; $display("FAIL rmid_ftick16: got %b want 1", frame_tick);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_glyphs();
        test_back_to_back();
        test_blink();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
